// File: rtl/jtframe_6809_romcache.sv
// Two-entry tagged word cache between the 6809 ROM bus and the SDRAM ROM port.
// Hits answer combinationally; misses issue one SDRAM word request at a time.
module jtframe_6809_romcache #(
    parameter int AW   = 15,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rom_cs,
    input  logic [AW-1:0]   rom_addr,
    input  logic            flush,
    output logic            rom_ok,
    output logic [7:0]      rom_dout,
    output logic            sdram_req,
    output logic [AW-2:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            sdram_dok,
    input  logic [15:0]     sdram_data,
    output logic [CNTW-1:0] miss_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_n;
    logic [1:0]    valid;
    logic [AW-2:0] tag  [2];
    logic [15:0]   data [2];
    logic          victim;
    logic          stale;
    logic [1:0]    match;
    logic [AW-2:0] word_addr;
    logic [15:0]   hit_word;
    logic          start;
    logic          done;
    logic          fill;

    assign word_addr = rom_addr[AW-1:1];

    always_comb begin
        match = '0;
        for (int e = 0; e < 2; e++)
            match[e] = rom_cs & valid[e] & (tag[e] == word_addr);
    end

    assign rom_ok   = |match;
    assign hit_word = match[0] ? data[0] : data[1];
    assign rom_dout = rom_ok ? (rom_addr[0] ? hit_word[15:8] : hit_word[7:0]) : 8'd0;

    // done marks the end of a transaction; the word is only kept if no flush
    // arrived while it was in flight or in the same cycle
    always_comb begin
        state_n = state;
        start   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (rom_cs && !rom_ok && !flush) begin
                state_n = REQ;
                start   = 1'b1;
            end
            REQ: if (sdram_ack) begin
                done    = sdram_dok;
                state_n = sdram_dok ? IDLE : WAIT;
            end
            WAIT: if (sdram_dok) begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign fill = done & ~stale & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            miss_cnt   <= '0;
            stale      <= 1'b0;
        end else begin
            if (start) begin
                sdram_req  <= 1'b1;
                sdram_addr <= word_addr;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNTW'(1);
            end else if (state == REQ && sdram_ack) begin
                sdram_req  <= 1'b0;
            end
            if (done)                        stale <= 1'b0;
            else if (flush && state != IDLE) stale <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid  <= '0;
            victim <= 1'b0;
            tag    <= '{default: '0};
            data   <= '{default: '0};
        end else begin
            if (flush)     valid         <= '0;
            else if (fill) valid[victim] <= 1'b1;
            if (fill) begin
                tag[victim]  <= sdram_addr;
                data[victim] <= sdram_data;
                victim       <= ~victim;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_6809_romcache.sv
// Scoreboard bench for jtframe_6809_romcache: a FIFO-of-two cache model predicts
// hit/miss, bytes and miss count; a monitor checks every rom_ok the DUT presents.
module tb_jtframe_6809_romcache;
    localparam int AW   = 15;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            rom_cs = 1'b0;
    logic [AW-1:0]   rom_addr = '0;
    logic            flush = 1'b0;
    logic            rom_ok;
    logic [7:0]      rom_dout;
    logic            sdram_req;
    logic [AW-2:0]   sdram_addr;
    logic            sdram_ack = 1'b0;
    logic            sdram_dok = 1'b0;
    logic [15:0]     sdram_data = '0;
    logic [CNTW-1:0] miss_cnt;

    always #5 clk = ~clk;

    jtframe_6809_romcache #(.AW(AW), .CNTW(CNTW)) dut (
        .clk(clk), .rstn(rstn), .rom_cs(rom_cs), .rom_addr(rom_addr), .flush(flush),
        .rom_ok(rom_ok), .rom_dout(rom_dout), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .sdram_data(sdram_data), .miss_cnt(miss_cnt)
    );

    typedef struct { logic [AW-1:0] a; logic [7:0] b; bit miss; } exp_t;

    exp_t          expq[$];
    logic [AW-2:0] mq[$];
    logic [15:0]   rom_ovr[int];
    int passed = 0, total = 0, served = 0, misses = 0, cyc = 0, dok_cyc = -10;
    int ack_dly = 0, dok_dly = 0;
    int rsp_phase = 0, rsp_cnt = 0;
    logic [AW-2:0] rsp_wa = '0;
    logic [AW-2:0] base = '0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input bit ok, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    endfunction

    function automatic logic [15:0] rom_word(input logic [AW-2:0] w);
        if (rom_ovr.exists(int'(w))) return rom_ovr[int'(w)];
        return 16'(int'(w) * 40503 + 4660);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
        logic [15:0] wd;
        wd = rom_word(a[AW-1:1]);
        return a[0] ? wd[15:8] : wd[7:0];
    endfunction

    function automatic bit mdl_hit(input logic [AW-2:0] w);
        foreach (mq[i]) if (mq[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void mdl_fill(input logic [AW-2:0] w);
        mq.push_back(w);
        if (mq.size() > 2) void'(mq.pop_front());
    endfunction

    function automatic int sat_miss();
        return (misses > 15) ? 15 : misses;
    endfunction

    // SDRAM side: ack after ack_dly cycles, dok dok_dly cycles after ack (0 = same cycle)
    initial begin
        forever begin
            @(posedge clk); #1;
            sdram_ack = 1'b0;
            sdram_dok = 1'b0;
            if (!rstn) rsp_phase = 0;
            else if (rsp_phase == 2) begin
                if (rsp_cnt == 0) begin
                    sdram_dok = 1'b1; sdram_data = rom_word(rsp_wa); dok_cyc = cyc; rsp_phase = 0;
                end else rsp_cnt--;
            end else begin
                if (rsp_phase == 0 && sdram_req) begin
                    rsp_wa = sdram_addr; rsp_cnt = ack_dly; rsp_phase = 1;
                end
                if (rsp_phase == 1) begin
                    if (rsp_cnt == 0) begin
                        sdram_ack = 1'b1;
                        if (dok_dly == 0) begin
                            sdram_dok = 1'b1; sdram_data = rom_word(rsp_wa); dok_cyc = cyc; rsp_phase = 0;
                        end else begin
                            rsp_cnt = dok_dly - 1; rsp_phase = 2;
                        end
                    end else rsp_cnt--;
                end
            end
        end
    end

    // Monitor: every rom_ok with rom_cs must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rom_cs && rom_ok) begin
                    chk("unexpected_ok", expq.size() != 0, 1, 0);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("dout", rom_dout == e.b && rom_addr == e.a, rom_dout, e.b);
                        if (e.miss) chk("ok_latency", cyc == dok_cyc + 1, cyc, dok_cyc + 1);
                        served++;
                    end
                end else if (!rom_cs) begin
                    chk("idle_out", !rom_ok && rom_dout == 8'd0, {rom_ok, rom_dout}, 0);
                end
            end
        end
    end

    task automatic do_flush();
        rom_cs = 1'b0;
        flush  = 1'b1;
        @(posedge clk); #1;
        flush  = 1'b0;
        mq.delete();
    endtask

    // fl: 0 plain, 1 flush together with a missing access, 2 flush while the miss is in flight
    task automatic access(input logic [AW-1:0] a, input int fl);
        logic [AW-2:0] w;
        bit h;
        int tgt, n;
        w = a[AW-1:1];
        if (fl == 1) mq.delete();
        h = mdl_hit(w);
        if (!h) begin
            mdl_fill(w); misses++;
            if (fl == 2) begin mq.delete(); mdl_fill(w); misses++; end
        end
        expq.push_back('{a: a, b: exp_byte(a), miss: !h});
        tgt = served + 1;
        rom_cs = 1'b1; rom_addr = a; flush = (fl == 1);
        @(posedge clk); #1;
        flush = 1'b0;
        if (h)            chk("hit_now", served == tgt && !sdram_req, served, tgt);
        else if (fl == 1) chk("flush_blocks_req", !sdram_req, sdram_req, 0);
        else              chk("miss_req", sdram_req && sdram_addr == w, {sdram_req, sdram_addr}, {1'b1, w});
        if (fl == 2 && !h) begin
            @(posedge clk); #1; flush = 1'b1;
            @(posedge clk); #1; flush = 1'b0;
        end
        n = 0;
        while (served < tgt && n < 300) begin @(posedge clk); #1; n++; end
        chk("served", served >= tgt, served, tgt);
        chk("miss_cnt", miss_cnt == CNTW'(sat_miss()), miss_cnt, sat_miss());
    endtask

    initial begin
        logic [AW-2:0] w;
        int r, fl;
        repeat (3) @(posedge clk); #1;
        chk("rst_ok", rom_ok == 1'b0 && rom_dout == 8'd0, {rom_ok, rom_dout}, 0);
        chk("rst_req", sdram_req == 1'b0, sdram_req, 0);
        chk("rst_addr", sdram_addr == '0, sdram_addr, 0);
        chk("rst_cnt", miss_cnt == '0, miss_cnt, 0);
        rstn = 1'b1; mon_en = 1'b1;
        @(posedge clk); #1;

        // reset in the middle of a WAIT
        ack_dly = 0; dok_dly = 20;
        rom_cs = 1'b1; rom_addr = 15'h1234;
        repeat (4) @(posedge clk); #1;
        rstn = 1'b0; #1;
        chk("mid_rst_req", !sdram_req, sdram_req, 0);
        chk("mid_rst_ok", !rom_ok, rom_ok, 0);
        chk("mid_rst_cnt", miss_cnt == '0, miss_cnt, 0);
        repeat (2) @(posedge clk); #1;
        rom_cs = 1'b0; rstn = 1'b1;
        mq.delete(); misses = 0;
        @(posedge clk); #1;
        ack_dly = 1; dok_dly = 1;
        access(15'h1234, 0);

        // miss then hit on the other byte
        do_flush();
        rom_ovr[int'(15'h0101 >> 1)] = 16'hBEEF;
        ack_dly = 1; dok_dly = 2;
        access(15'h0101, 0);
        access(15'h0100, 0);

        // two lines, FIFO eviction, full-width tag compare
        do_flush();
        ack_dly = 0; dok_dly = 1;
        access(15'h0020, 0); access(15'h0040, 0);
        access(15'h0021, 0); access(15'h0041, 0); access(15'h0021, 0); access(15'h0041, 0);
        access(15'h0060, 0); access(15'h0041, 0); access(15'h0020, 0);
        access(15'h4020, 0); access(15'h0021, 0);

        // flush during WAIT discards the fill and the miss is replayed
        rom_ovr[int'(15'h0202 >> 1)] = 16'h5555;
        ack_dly = 0; dok_dly = 3;
        access(15'h0202, 2);
        access(15'h0203, 0);

        // ack and dok together
        rom_ovr[int'(15'h0300 >> 1)] = 16'hA5C3;
        ack_dly = 0; dok_dly = 0;
        access(15'h0300, 0);
        access(15'h0301, 0);

        // flush and a new miss in the same cycle
        ack_dly = 1; dok_dly = 0;
        access(15'h0500, 1);

        // miss counter saturation
        do_flush();
        ack_dly = 0; dok_dly = 0;
        for (int i = 0; i < 20; i++) access(AW'((32'h200 + i) << 1), 0);
        chk("cnt_sat", miss_cnt == 4'hF, miss_cnt, 4'hF);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            if (i % 25 == 0) base = (AW-1)'($urandom_range(0, (1 << (AW-1)) - 8));
            w = base + (AW-1)'($urandom_range(0, 4));
            ack_dly = $urandom_range(0, 3);
            dok_dly = $urandom_range(0, 3);
            r = $urandom_range(0, 99);
            fl = 0;
            if (r < 8) do_flush();
            else if (r < 16 && !mdl_hit(w)) fl = 1;
            else if (r < 24 && !mdl_hit(w)) begin
                fl = 2;
                if (ack_dly + dok_dly == 0) dok_dly = 1;
            end
            access({w, 1'($urandom_range(0, 1))}, fl);
            if ($urandom_range(0, 3) == 0) begin
                rom_cs = 1'b0;
                @(posedge clk); #1;
            end
        end

        rom_cs = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("queue_empty", expq.size() == 0, expq.size(), 0);
        chk("miss_final", miss_cnt == CNTW'(sat_miss()), miss_cnt, sat_miss());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
